div_shft_sub: RTL and testbench

Sequential restoring shift-subtract divider: the inverse of the shift-add multiplier in the same arithmetic datapath. It accepts a dividend/divisor pair on a start handshake and iterates one quotient bit per clock. It then presents the quotient and remainder with a ready indication. Signed and unsigned modes are supported, and divide-by-zero and signed-overflow results are fixed and deterministic.

---
 rtl/mul_div_pkg.sv | 19 +
 rtl/div_shft_sub_twos_abs.sv | 13 +
 rtl/div_shft_sub.sv | 132 +++++++++++++
 tb/tb_div_shft_sub.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_pkg.sv
// Shared definitions for the sequential multiply/divide datapath.
package mul_div_pkg;

  // Controller states shared by the shift-add multiplier and shift-subtract divider
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Quotient reported for a zero divisor; sliced down to the datapath width
  localparam logic [1023:0] DIV_ZERO_Q = '1;

  // Bits needed for an iteration counter that holds the value w
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_shft_sub_twos_abs.sv
// Conditional two's-complement negate: magnitude extraction and sign restoration.
module twos_abs #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  // Negating the most negative value wraps to itself, which reads correctly as unsigned
  assign y = neg ? (~a + 1'b1) : a;

endmodule

// File: rtl/div_shft_sub.sv
// Restoring shift-subtract divider, one quotient bit per clock, signed/unsigned.
module div_shft_sub
  import mul_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t          state;
  logic [CW-1:0]   cnt;
  // Partial remainder is always below the divisor magnitude after an iteration,
  // so WIDTH bits hold it; the extra bit only exists in the shifted trial value.
  logic [WIDTH-1:0] rem_part;
  logic [WIDTH-1:0] quo_part;
  logic [WIDTH-1:0] dvsr_mag;
  logic [WIDTH-1:0] dvnd_orig;
  logic             q_neg;
  logic             r_neg;
  logic             zero_div;

  logic [WIDTH-1:0] dvnd_abs;
  logic [WIDTH-1:0] dvsr_abs;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;

  twos_abs #(.WIDTH(WIDTH)) u_abs_dvnd (
    .neg (sign & dividend[WIDTH-1]),
    .a   (dividend),
    .y   (dvnd_abs)
  );

  twos_abs #(.WIDTH(WIDTH)) u_abs_dvsr (
    .neg (sign & divisor[WIDTH-1]),
    .a   (divisor),
    .y   (dvsr_abs)
  );

  twos_abs #(.WIDTH(WIDTH)) u_fix_quo (
    .neg (q_neg),
    .a   (quo_part),
    .y   (q_fix)
  );

  twos_abs #(.WIDTH(WIDTH)) u_fix_rem (
    .neg (r_neg),
    .a   (rem_part),
    .y   (r_fix)
  );

  // Shift the next dividend bit into the partial remainder and try subtracting
  always_comb begin
    rem_shift = {rem_part, quo_part[WIDTH-1]};
    trial     = rem_shift - {1'b0, dvsr_mag};
  end

  // Controller and datapath: load, iterate WIDTH times, then sign-fix into outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ready       <= 1'b1;
      cnt         <= '0;
      rem_part    <= '0;
      quo_part    <= '0;
      dvsr_mag    <= '0;
      dvnd_orig   <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      zero_div    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rem_part  <= '0;
            quo_part  <= dvnd_abs;
            dvsr_mag  <= dvsr_abs;
            dvnd_orig <= dividend;
            q_neg     <= sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg     <= sign & dividend[WIDTH-1];
            zero_div  <= (divisor == '0);
            cnt       <= CW'(WIDTH);
            ready     <= 1'b0;
            state     <= CALC;
          end
        end
        CALC: begin
          // A clear sign bit on the trial means the subtraction fits
          rem_part <= trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
          quo_part <= {quo_part[WIDTH-2:0], ~trial[WIDTH]};
          cnt      <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (zero_div) begin
            quotient    <= DIV_ZERO_Q[WIDTH-1:0];
            remainder   <= dvnd_orig;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= q_fix;
            remainder   <= r_fix;
            div_by_zero <= 1'b0;
          end
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_shft_sub.sv
// Scoreboard bench for div_shft_sub: directed cases plus a randomized sweep.
module tb_div_shft_sub;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sign;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  div_shft_sub #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .sign        (sign),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the bench can never hang
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
    exp_t e;
    e.q  = q;
    e.r  = r;
    e.dz = dz;
    return e;
  endfunction

  // Reference: plain 64-bit integer division, truncating toward zero
  function automatic exp_t ref_div(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint na;
    longint nb;
    if (b == '0) begin
      e = mk('1, a, 1'b1);
    end else begin
      if (s) begin
        na = longint'($signed(a));
        nb = longint'($signed(b));
      end else begin
        na = longint'(a);
        nb = longint'(b);
      end
      e = mk(W'(na / nb), W'(na % nb), 1'b0);
    end
    return e;
  endfunction

  // Monitor: every rising edge of ready delivers one result to compare
  initial begin
    logic prev_ready;
    exp_t e;
    prev_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && ready && !prev_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got q=%h r=%h dz=%b, expected none", quotient, remainder, div_by_zero);
        end else begin
          e = exp_q.pop_front();
          check("quotient", quotient, e.q);
          check("remainder", remainder, e.r);
          check("div_by_zero", div_by_zero, e.dz);
          $display("result q=%h r=%h dz=%b", quotient, remainder, div_by_zero);
        end
      end
      prev_ready = ready;
    end
  end

  // Issue one operation and check busy indication and load-to-ready latency
  task automatic run_op(input bit s, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
    int n;
    @(negedge clk);
    sign     = s;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    start    = 1'b0;
    sign     = 1'($urandom);
    dividend = $urandom;
    divisor  = $urandom;
    check("busy_after_load", ready, 1'b0);
    n = 0;
    while (!ready && n < W + 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, W + 1);
  endtask

  initial begin
    int   n;
    int   sel;
    bit   s;
    logic [W-1:0] a;
    logic [W-1:0] b;

    rst_n    = 1'b0;
    start    = 1'b0;
    sign     = 1'b0;
    dividend = '0;
    divisor  = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", ready, 1'b1);
    check("rst_quotient", quotient, '0);
    check("rst_remainder", remainder, '0);
    check("rst_dz", div_by_zero, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases with hand-computed results
    run_op(1'b0, 32'd100, 32'd7, mk(32'd14, 32'd2, 1'b0));
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, mk(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0));
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, mk(32'hFFFF_FFFD, 32'd1, 1'b0));
    run_op(1'b0, 32'd5, 32'd0, mk(32'hFFFF_FFFF, 32'd5, 1'b1));
    run_op(1'b1, 32'hFFFF_FFFB, 32'd0, mk(32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1));
    run_op(1'b0, 32'd9, 32'd3, mk(32'd3, 32'd0, 1'b0));
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'h8000_0000, 32'd0, 1'b0));
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'd0, 32'h8000_0000, 1'b0));

    // A start pulse while busy must be ignored
    @(negedge clk);
    sign = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    exp_q.push_back(mk(32'd14, 32'd2, 1'b0));
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    sign = 1'b1; dividend = 32'd55; divisor = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!ready && n < W + 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("busy_wait", ready, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("busy_no_restart", ready, 1'b1);

    // Start held high: back-to-back results every W+2 cycles
    @(negedge clk);
    sign = 1'b0; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    for (int k = 0; k < 3; k++) exp_q.push_back(mk(32'd333, 32'd1, 1'b0));
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
      end while (!ready && n < 2 * W + 20);
      if (k == 2) start = 1'b0;
      check(k == 0 ? "b2b_first" : "b2b_period", n, k == 0 ? W + 1 : W + 2);
    end

    // Reset in the middle of CALC discards the operation
    @(negedge clk);
    sign = 1'b0; dividend = 32'd12345; divisor = 32'd17; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", ready, 1'b1);
    check("midrst_quotient", quotient, '0);
    check("midrst_remainder", remainder, '0);
    check("midrst_dz", div_by_zero, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 32'd1000, 32'd10, mk(32'd100, 32'd0, 1'b0));

    // Randomized sweep against the reference model
    for (int i = 0; i < 1000; i++) begin
      s   = 1'($urandom);
      a   = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: b = '0;
        1: b = W'($urandom_range(1, 15));
        2: begin a = 32'h8000_0000; b = '1; end
        3: b = -W'($urandom_range(1, 15));
        4: b = a >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      run_op(s, a, b, ref_div(s, a, b));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
